// File: rtl/tt_not_gate_pkg.sv
// Shared types and constants for the NOT-gate pattern driver and its
// pattern generator: FSM state encoding, pattern-source selector and the
// LFSR tap mask / seed used for pseudo-random runs.
package tt_not_gate_pkg;

    // Run-control FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Pattern source selected by the mode input at start.
    typedef enum logic {
        PAT_SWEEP = 1'b0,
        PAT_LFSR  = 1'b1
    } pat_mode_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback is the XOR of bits 7,5,4,3.
    localparam logic [7:0]  LFSR_TAPS_W8 = 8'hB8;

    // Every LFSR run starts here; the run ends on the pattern whose successor
    // would be the seed again.
    localparam int unsigned LFSR_SEED    = 1;

    // Settle counter width, matching the settle_cycles input.
    localparam int unsigned SETTLE_W     = 4;

    // Maximal-length tap masks for a few bus widths; anything else falls back
    // to the 8-bit mask, which is the width the driver is normally built for.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return {24'h0, LFSR_TAPS_W8};
            default: return {24'h0, LFSR_TAPS_W8};
        endcase
    endfunction

endpackage

// File: rtl/tt_pattern_gen.sv
// Pattern source for the NOT-gate driver. Holds the current pattern, loads the
// first pattern of a run, advances on request and flags the last pattern.
// Sweep mode counts 0..2^W-1; LFSR mode walks a maximal-length Fibonacci LFSR
// from the seed, so the all-zero pattern never appears.
module tt_pattern_gen
    import tt_not_gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic         i_mode,
    output logic [W-1:0] o_pattern,
    output logic         o_last
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
    localparam logic [W-1:0] SEED = W'(LFSR_SEED);

    logic [W-1:0] r_pattern;
    pat_mode_t    r_mode;

    logic         w_feedback;
    logic [W-1:0] w_lfsr_next;
    logic [W-1:0] w_sweep_next;
    logic [W-1:0] w_first;

    assign w_feedback   = ^(r_pattern & TAPS);
    assign w_lfsr_next  = {r_pattern[W-2:0], w_feedback};
    assign w_sweep_next = r_pattern + W'(1);
    assign w_first      = (pat_mode_t'(i_mode) == PAT_LFSR) ? SEED : '0;

    // Last pattern: all-ones in sweep mode, predecessor of the seed in LFSR mode.
    assign o_last    = (r_mode == PAT_LFSR) ? (w_lfsr_next == SEED)
                                            : (r_pattern == '1);
    assign o_pattern = r_pattern;

    // Latch the source at load time and step the pattern on each advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_mode    <= PAT_SWEEP;
        end else if (i_load) begin
            r_pattern <= w_first;
            r_mode    <= pat_mode_t'(i_mode);
        end else if (i_advance) begin
            r_pattern <= (r_mode == PAT_LFSR) ? w_lfsr_next : w_sweep_next;
        end
    end

endmodule

// File: rtl/tt_not_gate_driver.sv
// Test driver for a bank of NOT gates. Each pattern is driven on drv_out,
// given settle_cycles cycles to propagate, then the response on dut_in is
// compared with the expected value (~pattern, or pattern when INVERT=0).
// Mismatches are counted and the first failing pattern is captured; done
// pulses at the end of a run and pass reports a clean run.
module tt_not_gate_driver
    import tt_not_gate_pkg::*;
#(
    parameter int W      = 8,
    parameter bit INVERT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [W-1:0]        drv_out,
    input  logic [W-1:0]        dut_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [W:0]          err_count,
    output logic [W-1:0]        first_err_pat,
    output logic                first_err_valid
);

    state_t              r_state;
    state_t              w_state_next;
    logic [SETTLE_W-1:0] r_settle_len;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [W:0]          r_err_count;
    logic [W-1:0]        r_first_err_pat;
    logic                r_first_err_valid;

    logic                w_load;
    logic                w_advance;
    logic                w_last;
    logic [W-1:0]        w_pattern;
    logic [W-1:0]        w_expected;
    logic                w_mismatch;

    // Pattern source: sweep counter or LFSR, with last-pattern detection.
    tt_pattern_gen #(
        .W (W)
    ) u_pattern_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_advance (w_advance),
        .i_mode    (mode),
        .o_pattern (w_pattern),
        .o_last    (w_last)
    );

    // The generator's pattern register drives the pins directly, so the value
    // appears in the APPLY cycle and is held through IDLE after a run.
    assign drv_out = w_pattern;

    assign w_expected = INVERT ? ~w_pattern : w_pattern;
    assign w_mismatch = (r_state == ST_SAMPLE) && (dut_in != w_expected);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus pattern load/advance strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_APPLY;
                    w_load       = 1'b1;
                end
            end
            ST_APPLY: begin
                w_state_next = (r_settle_len != '0) ? ST_SETTLE : ST_SAMPLE;
            end
            ST_SETTLE: begin
                // Counter holds the remaining settle cycles including this one.
                if (r_settle_cnt == SETTLE_W'(1)) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_state_next = ST_APPLY;
                    w_advance    = 1'b1;
                end
            end
            ST_FINISH: begin
                // start is deliberately not looked at here.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Settle length is latched at start; the counter reloads in every APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_len <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (w_load) begin
                r_settle_len <= settle_cycles;
            end
            if (r_state == ST_APPLY) begin
                r_settle_cnt <= r_settle_len;
            end else if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
            end
        end
    end

    // Registered status flags: busy outside IDLE, done for the FINISH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_FINISH);
        end
    end

    // Response checker: clear on start, count mismatches, capture the first,
    // and publish the pass verdict when the run finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_pat   <= '0;
            r_first_err_valid <= 1'b0;
        end else if (w_load) begin
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            if (w_mismatch) begin
                // At most 2^W samples per run, so W+1 bits can never wrap.
                r_err_count <= r_err_count + (W+1)'(1);
                if (!r_first_err_valid) begin
                    r_first_err_pat   <= w_pattern;
                    r_first_err_valid <= 1'b1;
                end
            end
            if (r_state == ST_FINISH) begin
                r_pass <= (r_err_count == '0);
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_pat   = r_first_err_pat;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_tt_not_gate_driver.sv
// Directed bench for tt_not_gate_driver (W=8, INVERT=1). The DUT model is an
// inverter on the driven pins, optionally with output bit 0 stuck at 1.
module tb_tt_not_gate_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] settle_cycles;
    logic [7:0] drv_out;
    logic [7:0] dut_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [7:0] first_err_pat;
    logic       first_err_valid;

    logic       stuck0 = 1'b0;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc    = 0;

    int         r_len;
    int         r_distinct;
    int         r_first;
    int         r_last;
    bit         seen [256];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dut_in = stuck0 ? (~drv_out | 8'h01) : ~drv_out;

    tt_not_gate_driver #(
        .W      (8),
        .INVERT (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .settle_cycles   (settle_cycles),
        .drv_out         (drv_out),
        .dut_in          (dut_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_pat   (first_err_pat),
        .first_err_valid (first_err_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One run from an idle negedge. disturb pulses start and changes mode and
    // settle mid-run; fin_start raises start during the FINISH cycle.
    task automatic run(input string tag, input logic m, input logic [3:0] s,
                       input bit disturb, input bit fin_start);
        int t0;
        int guard;
        foreach (seen[i]) seen[i] = 1'b0;
        start         = 1'b1;
        mode          = m;
        settle_cycles = s;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        check({tag, " busy at start"}, busy, 1);
        check({tag, " err cleared"}, err_count, 0);
        check({tag, " fev cleared"}, first_err_valid, 0);
        r_first = drv_out;
        guard   = 0;
        while (!done && guard < 5000) begin
            seen[drv_out] = 1'b1;
            if (disturb && guard == 100) begin
                start         = 1'b1;
                settle_cycles = 4'd5;
                mode          = ~m;
            end
            if (disturb && guard == 101) start = 1'b0;
            @(negedge clk);
            guard++;
        end
        check({tag, " done seen"}, done, 1);
        r_len         = cyc - t0;
        r_last        = drv_out;
        seen[drv_out] = 1'b1;
        r_distinct    = 0;
        foreach (seen[i]) if (seen[i]) r_distinct++;
        if (fin_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " busy after run"}, busy, 0);
        @(negedge clk);
        check({tag, " still idle"}, busy, 0);
    endtask

    initial begin
        int guard;
        int n_done;
        rst           = 1'b1;
        start         = 1'b0;
        mode          = 1'b0;
        settle_cycles = 4'd0;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst err_count", err_count, 0);
        check("rst drv_out", drv_out, 0);
        check("rst first_err_pat", first_err_pat, 0);
        check("rst first_err_valid", first_err_valid, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle without start", busy, 0);

        // Ideal inverter, sweep, no settle: 256 patterns x 2 cycles.
        run("sweep", 1'b0, 4'd0, 1'b0, 1'b0);
        check("sweep length", r_len, 512);
        check("sweep distinct", r_distinct, 256);
        check("sweep first", r_first, 8'h00);
        check("sweep last", r_last, 8'hFF);
        check("sweep pass", pass, 1);
        check("sweep err_count", err_count, 0);
        check("sweep fev", first_err_valid, 0);

        // Ideal inverter, LFSR, settle 3: 255 patterns x 5 cycles.
        run("lfsr", 1'b1, 4'd3, 1'b0, 1'b0);
        check("lfsr length", r_len, 1275);
        check("lfsr distinct", r_distinct, 255);
        check("lfsr zero never driven", seen[0], 0);
        check("lfsr first", r_first, 8'h01);
        check("lfsr last", r_last, 8'h80);
        check("lfsr pass", pass, 1);

        // Bit 0 stuck at 1: every odd pattern mismatches. Start during FINISH.
        stuck0 = 1'b1;
        run("stuck", 1'b0, 4'd0, 1'b0, 1'b1);
        check("stuck err_count", err_count, 128);
        check("stuck first_err_pat", first_err_pat, 8'h01);
        check("stuck fev", first_err_valid, 1);
        check("stuck pass", pass, 0);

        // Back-to-back passing run: start clears the failing results.
        stuck0 = 1'b0;
        run("b2b", 1'b0, 4'd0, 1'b0, 1'b0);
        check("b2b pass", pass, 1);
        check("b2b err_count", err_count, 0);
        check("b2b fev", first_err_valid, 0);

        // Start, mode and settle disturbed mid-run: settle 1 -> 256 x 3 cycles.
        run("disturb", 1'b0, 4'd1, 1'b1, 1'b0);
        check("disturb length", r_len, 768);
        check("disturb distinct", r_distinct, 256);
        check("disturb pass", pass, 1);

        // Reset mid-run at pattern 0x40 with the stuck fault present.
        stuck0        = 1'b1;
        start         = 1'b1;
        mode          = 1'b0;
        settle_cycles = 4'd0;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (drv_out != 8'h40 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("abort reached 0x40", drv_out, 8'h40);
        check("abort err before rst", err_count, 32);
        #1 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort drv_out", drv_out, 0);
        check("abort err_count", err_count, 0);
        check("abort done", done, 0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (600) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort no done", n_done, 0);
        check("abort stays idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tt_not_gate_driver.md
TT_NOT_GATE_DRIVER -- requirements
Module: tt_not_gate_driver

Interface
REQ-001 SHALL expose parameter W, default 8: pin-bus width.
REQ-002 SHALL expose parameter INVERT, default 1: 1 = expected response is ~pattern; 0 = expected response is pattern.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a test run; sampled only in IDLE.
REQ-006 mode  input  1  0 = incrementing sweep 0..2^W-1; 1 = LFSR sequence.
REQ-007 settle_cycles  input  4  wait cycles between driving a pattern and sampling the response.
REQ-008 drv_out  output  W  pattern driven to the DUT's dedicated inputs.
REQ-009 dut_in  input  W  DUT's dedicated outputs, sampled for comparison.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 pass  output  1  high when the last completed run had zero mismatches.
REQ-013 err_count  output  W+1  mismatches counted in the current or last run.
REQ-014 first_err_pat  output  W  pattern that produced the first mismatch.
REQ-015 first_err_valid  output  1  first_err_pat holds a captured value.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, SETTLE, SAMPLE, FINISH.
REQ-017 IDLE + start=1 SHALL go to APPLY and, at that edge, clear err_count, pass and first_err_valid, latch mode and settle_cycles, and load the first pattern: 0x00 in sweep mode, 0x01 in LFSR mode.
REQ-018 APPLY SHALL drive the current pattern on drv_out and load the settle counter with the latched settle_cycles. Next state: SETTLE if settle_cycles != 0, else SAMPLE.
REQ-019 SETTLE SHALL decrement the counter each cycle and go to SAMPLE on the cycle the counter reaches 0 (exactly settle_cycles cycles spent in SETTLE).
REQ-020 SAMPLE SHALL compare dut_in against the expected value (~pattern if INVERT=1, else pattern).
REQ-021 On a mismatch, SAMPLE SHALL increment err_count; if first_err_valid=0, it SHALL also capture the pattern into first_err_pat and set first_err_valid.
REQ-022 After SAMPLE, the next state SHALL be FINISH if the pattern was the last one, else APPLY with the next pattern.
REQ-023 Sweep mode: next = pattern+1; last pattern = 2^W-1; total 2^W patterns.
REQ-024 LFSR mode: Fibonacci LFSR, W=8 taps x^8+x^6+x^5+x^4+1, seed 0x01; last pattern is the one whose successor is 0x01; total 255 patterns; 0x00 never driven.
REQ-025 Each pattern SHALL occupy exactly settle_cycles+2 cycles (APPLY + SETTLE + SAMPLE).
REQ-026 FINISH SHALL pulse done for one cycle, set pass = (err_count==0), and return to IDLE.
REQ-027 busy SHALL be 1 in APPLY, SETTLE, SAMPLE and FINISH, and 0 in IDLE.
REQ-028 start while not in IDLE SHALL be ignored.
REQ-029 start high in the FINISH cycle SHALL be ignored; a new run needs start in a later IDLE cycle.
REQ-030 Changes to mode or settle_cycles during a run SHALL have no effect until the next start.
REQ-031 drv_out SHALL hold its last driven pattern while in IDLE.
REQ-032 err_count SHALL never wrap; its maximum is 2^W, which fits W+1 bits.

Reset
REQ-033 rst=1 SHALL asynchronously force the following, aborting any run in progress: state IDLE, drv_out 0, busy 0, done 0, pass 0, err_count 0, first_err_pat 0, first_err_valid 0, settle counter 0.
REQ-034 After rst deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Structure
REQ-035 FSM state enum, LFSR tap mask and seed constants SHALL live in shared package tt_not_gate_pkg.
REQ-036 The pattern source SHALL be sub-module tt_pattern_gen (sweep/LFSR select, load, advance, last flag); FSM and checker remain in the top module.

Verification
REQ-037 Ideal inverter DUT (dut_in=~drv_out), mode 0, settle 0, start pulse -> 256 patterns, done pulses exactly 512 cycles after the APPLY entry, pass=1, err_count=0.
REQ-038 Ideal inverter DUT, mode 1, settle 3 -> 255 distinct nonzero patterns, run length 255*5 cycles, pass=1.
REQ-039 DUT with bit 0 stuck at 1, mode 0, settle 0 -> err_count=128, first_err_pat=0x01, first_err_valid=1, pass=0.
REQ-040 rst asserted mid-run at pattern 0x40 -> on the same edge busy=0, drv_out=0 and err_count=0; no done pulse follows.
REQ-041 start pulsed again while busy, and settle_cycles changed mid-run -> neither affects the run: run length and pattern count are unchanged.
REQ-042 Back-to-back runs, failing then passing -> second start clears err_count and first_err_valid; pass=1 after the second done.
